// File: rtl/riscv_demux_buf.sv
// Registered 1-to-N valid/ready demultiplexer with a 2-entry in-order buffer.
// Beats carry a destination lane; out-of-range lanes are discarded with a drop pulse.
`ifndef XLEN
`define XLEN 32
`endif

module riscv_demux_buf #(
    parameter int N_DEMUX_OUT = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_demux_valid,
    output logic                          o_demux_ready,
    input  logic [$clog2(N_DEMUX_OUT)-1:0] i_demux_sel,
    input  logic [`XLEN-1:0]              i_demux_data,
    output logic [N_DEMUX_OUT-1:0]        o_demux_valid,
    input  logic [N_DEMUX_OUT-1:0]        i_demux_ready,
    output logic [N_DEMUX_OUT*`XLEN-1:0]  o_demux_concat_data,
    output logic                          o_demux_drop
);

    localparam int SEL_W = $clog2(N_DEMUX_OUT);
    localparam int XL    = `XLEN;

    logic [SEL_W-1:0] mem_sel  [2];
    logic [XL-1:0]    mem_data [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             drop_q;

    logic             push;
    logic             in_range;
    logic             wr_en;
    logic             pop;
    logic [SEL_W-1:0] head_sel;
    logic [XL-1:0]    head_data;

    // Ready depends only on occupancy, so destinations cannot create a loop through us.
    assign o_demux_ready = (count != 2'd2);
    assign push          = i_demux_valid & o_demux_ready;
    assign in_range      = ({{(32-SEL_W){1'b0}}, i_demux_sel} < 32'(N_DEMUX_OUT));
    assign wr_en         = push & in_range;
    assign head_sel      = mem_sel[rd_ptr];
    assign head_data     = mem_data[rd_ptr];
    assign o_demux_drop  = drop_q;

    always_comb begin
        o_demux_valid       = '0;
        o_demux_concat_data = '0;
        pop                 = 1'b0;
        if (count != 2'd0) begin
            for (int i = 0; i < N_DEMUX_OUT; i++) begin
                if (head_sel == SEL_W'(i)) begin
                    o_demux_valid[i]                = 1'b1;
                    o_demux_concat_data[i*XL +: XL] = head_data;
                    pop                             = i_demux_ready[i];
                end
            end
        end
    end

    // Storage needs no reset: entries are only observed while count says they are live.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem_sel[wr_ptr]  <= i_demux_sel;
            mem_data[wr_ptr] <= i_demux_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            drop_q <= 1'b0;
        end else begin
            drop_q <= push & ~in_range;
            if (wr_en) wr_ptr <= ~wr_ptr;
            if (pop)   rd_ptr <= ~rd_ptr;
            if (wr_en & ~pop)      count <= count + 2'd1;
            else if (pop & ~wr_en) count <= count - 2'd1;
        end
    end

endmodule
